// File: rtl/segapad_responder_pkg.sv
// Shared constants, button bundle and line-mapping helper for the Mega Drive
// style pad responder.
package segapad_responder_pkg;

    localparam int TIMEOUT_DEFAULT = 42000;

    localparam logic [2:0] P_IDLE   = 3'd0;
    localparam logic [2:0] P_DETECT = 3'd2;
    localparam logic [2:0] P_EXT    = 3'd3;
    localparam logic [2:0] P_SAT    = 3'd4;

    // Bit positions of the pad lines inside the 6-bit line vector.
    localparam int LN_UP    = 5;
    localparam int LN_DOWN  = 4;
    localparam int LN_LEFT  = 3;
    localparam int LN_RIGHT = 2;
    localparam int LN_B1    = 1;
    localparam int LN_B2    = 0;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic a;
        logic b;
        logic c;
        logic start;
        logic x;
        logic y;
        logic z;
        logic mode;
    } btn_t;

    // Active-low line levels for one (phase, select) combination.
    function automatic logic [5:0] map_lines(input logic [2:0] p, input logic sel,
                                             input logic six, input btn_t b);
        logic [5:0] l;
        l = '1;
        if (sel) begin
            l[LN_B1] = ~b.b;
            l[LN_B2] = ~b.c;
            if (six && p == P_EXT) begin
                l[LN_UP]    = ~b.z;
                l[LN_DOWN]  = ~b.y;
                l[LN_LEFT]  = ~b.x;
                l[LN_RIGHT] = ~b.mode;
            end else begin
                l[LN_UP]    = ~b.up;
                l[LN_DOWN]  = ~b.down;
                l[LN_LEFT]  = ~b.left;
                l[LN_RIGHT] = ~b.right;
            end
        end else begin
            l[LN_B1] = ~b.a;
            l[LN_B2] = ~b.start;
            if (six && p == P_DETECT) begin
                l[LN_UP]    = 1'b0;
                l[LN_DOWN]  = 1'b0;
                l[LN_LEFT]  = 1'b0;
                l[LN_RIGHT] = 1'b0;
            end else if (six && p == P_EXT) begin
                l[LN_UP]    = 1'b1;
                l[LN_DOWN]  = 1'b1;
                l[LN_LEFT]  = 1'b1;
                l[LN_RIGHT] = 1'b1;
            end else begin
                l[LN_UP]    = ~b.up;
                l[LN_DOWN]  = ~b.down;
                l[LN_LEFT]  = 1'b0;
                l[LN_RIGHT] = 1'b0;
            end
        end
        return l;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser bringing the host select line into the clk28 domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/segapad_responder.sv
// Pad-side responder: counts host select pulses into a phase and drives the
// six active-low pad lines for the current phase and select level.
module segapad_responder
    import segapad_responder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int SIX_BUTTON     = 1
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       joy_sel,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_c,
    input  logic       btn_start,
    input  logic       btn_x,
    input  logic       btn_y,
    input  logic       btn_z,
    input  logic       btn_mode,
    output logic       n_joy_up,
    output logic       n_joy_down,
    output logic       n_joy_left,
    output logic       n_joy_right,
    output logic       n_joy_b1,
    output logic       n_joy_b2,
    output logic       polled,
    output logic [2:0] dbg_phase
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic SIX = (SIX_BUTTON != 0);

    logic              sel_sync;
    logic              sel_prev_q, sel_prev_d;
    logic [2:0]        p_q, p_d, p_base;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              polled_q, polled_d;
    logic [5:0]        lines_q, lines_d;
    logic              rise;
    logic              timeout;
    btn_t              btns;

    sync2 u_sync (
        .clk   (clk28),
        .rst_n (rst_n),
        .d     (joy_sel),
        .q     (sel_sync)
    );

    assign btns = '{up: btn_up, down: btn_down, left: btn_left, right: btn_right,
                    a: btn_a, b: btn_b, c: btn_c, start: btn_start,
                    x: btn_x, y: btn_y, z: btn_z, mode: btn_mode};

    assign rise    = sel_sync & ~sel_prev_q;
    assign timeout = (idle_q == IDLE_LAST);

    // An edge arriving on the timeout cycle counts from a fresh phase 0.
    always_comb begin
        sel_prev_d = sel_sync;
        p_d        = p_q;
        idle_d     = idle_q;
        polled_d   = rise;
        p_base     = timeout ? P_IDLE : p_q;
        if (rise) begin
            p_d    = (p_base >= P_SAT) ? P_SAT : p_base + 3'd1;
            idle_d = '0;
        end else if (timeout) begin
            p_d = P_IDLE;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
        lines_d = map_lines(p_d, sel_sync, SIX, btns);
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sel_prev_q <= 1'b0;
            p_q        <= P_IDLE;
            idle_q     <= '0;
            polled_q   <= 1'b0;
            lines_q    <= '1;
        end else begin
            sel_prev_q <= sel_prev_d;
            p_q        <= p_d;
            idle_q     <= idle_d;
            polled_q   <= polled_d;
            lines_q    <= lines_d;
        end
    end

    assign n_joy_up    = lines_q[LN_UP];
    assign n_joy_down  = lines_q[LN_DOWN];
    assign n_joy_left  = lines_q[LN_LEFT];
    assign n_joy_right = lines_q[LN_RIGHT];
    assign n_joy_b1    = lines_q[LN_B1];
    assign n_joy_b2    = lines_q[LN_B2];
    assign polled      = polled_q;
    assign dbg_phase   = p_q;

endmodule

// File: tb/tb_segapad_responder.sv
// Directed bench for segapad_responder: six-button, three-button and
// short-timeout instances driven through host select sequences.
`timescale 1ns/1ps
module tb_segapad_responder;

    logic clk28 = 1'b0;
    logic rst_n = 1'b0;
    logic sel_m = 1'b0;
    logic sel_t = 1'b0;
    logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
    logic btn_a = 0, btn_b = 0, btn_c = 0, btn_start = 0;
    logic btn_x = 0, btn_y = 0, btn_z = 0, btn_mode = 0;

    wire [5:0] lines_m, lines_b, lines_t;
    wire       polled_m, polled_b, polled_t;
    wire [2:0] phase_m, phase_b, phase_t;

    int n_checks = 0;
    int n_pass   = 0;
    int polled_cnt = 0;

    initial forever #18 clk28 = ~clk28;

    always @(negedge clk28) if (polled_m === 1'b1) polled_cnt++;

    segapad_responder #(.TIMEOUT_CYCLES(42000), .SIX_BUTTON(1)) dut (
        .clk28(clk28), .rst_n(rst_n), .joy_sel(sel_m),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c), .btn_start(btn_start),
        .btn_x(btn_x), .btn_y(btn_y), .btn_z(btn_z), .btn_mode(btn_mode),
        .n_joy_up(lines_m[5]), .n_joy_down(lines_m[4]), .n_joy_left(lines_m[3]),
        .n_joy_right(lines_m[2]), .n_joy_b1(lines_m[1]), .n_joy_b2(lines_m[0]),
        .polled(polled_m), .dbg_phase(phase_m)
    );

    segapad_responder #(.TIMEOUT_CYCLES(42000), .SIX_BUTTON(0)) dut3 (
        .clk28(clk28), .rst_n(rst_n), .joy_sel(sel_m),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c), .btn_start(btn_start),
        .btn_x(btn_x), .btn_y(btn_y), .btn_z(btn_z), .btn_mode(btn_mode),
        .n_joy_up(lines_b[5]), .n_joy_down(lines_b[4]), .n_joy_left(lines_b[3]),
        .n_joy_right(lines_b[2]), .n_joy_b1(lines_b[1]), .n_joy_b2(lines_b[0]),
        .polled(polled_b), .dbg_phase(phase_b)
    );

    segapad_responder #(.TIMEOUT_CYCLES(40), .SIX_BUTTON(1)) dut_t (
        .clk28(clk28), .rst_n(rst_n), .joy_sel(sel_t),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c), .btn_start(btn_start),
        .btn_x(btn_x), .btn_y(btn_y), .btn_z(btn_z), .btn_mode(btn_mode),
        .n_joy_up(lines_t[5]), .n_joy_down(lines_t[4]), .n_joy_left(lines_t[3]),
        .n_joy_right(lines_t[2]), .n_joy_b1(lines_t[1]), .n_joy_b2(lines_t[0]),
        .polled(polled_t), .dbg_phase(phase_t)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk28);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic set_buttons(input logic a, input logic x, input logic mode);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        {btn_b, btn_c, btn_start, btn_y, btn_z} = 5'b00000;
        btn_a = a;
        btn_x = x;
        btn_mode = mode;
    endtask

    task automatic test_reset();
        set_buttons(1'b1, 1'b0, 1'b0);
        tick(3);
        n_checks++; if (lines_m !== 6'b111111) $display("FAIL reset_lines_m: got %b expected %b", lines_m, 6'b111111); else n_pass++;
        n_checks++; if (lines_b !== 6'b111111) $display("FAIL reset_lines_b: got %b expected %b", lines_b, 6'b111111); else n_pass++;
        n_checks++; if (lines_t !== 6'b111111) $display("FAIL reset_lines_t: got %b expected %b", lines_t, 6'b111111); else n_pass++;
        n_checks++; if (polled_m !== 1'b0) $display("FAIL reset_polled: got %b expected 0", polled_m); else n_pass++;
        n_checks++; if (phase_m !== 3'd0) $display("FAIL reset_phase: got %0d expected 0", phase_m); else n_pass++;
        rst_n = 1'b1;
        tick(1);
        n_checks++; if (lines_m !== 6'b110001) $display("FAIL release_lines_m: got %b expected %b", lines_m, 6'b110001); else n_pass++;
        n_checks++; if (lines_b !== 6'b110001) $display("FAIL release_lines_b: got %b expected %b", lines_b, 6'b110001); else n_pass++;
        n_checks++; if (lines_t !== 6'b110001) $display("FAIL release_lines_t: got %b expected %b", lines_t, 6'b110001); else n_pass++;
    endtask

    task automatic test_six_button_sequence();
        logic [5:0] exp_l [12];
        logic [2:0] exp_p [12];
        int cnt0;
        exp_l = '{6'b110001, 6'b111111, 6'b110001, 6'b111111, 6'b000001, 6'b110111,
                  6'b111101, 6'b111111, 6'b110001, 6'b111111, 6'b110001, 6'b111111};
        exp_p = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
        set_buttons(1'b1, 1'b1, 1'b0);
        sel_m = 1'b0;
        do_reset();
        cnt0 = polled_cnt;
        for (int k = 0; k < 12; k++) begin
            sel_m = (k % 2 == 1);
            tick(126);
            n_checks++; if (lines_m !== exp_l[k]) $display("FAIL seq6_lines step %0d: got %b expected %b", k, lines_m, exp_l[k]); else n_pass++;
            n_checks++; if (phase_m !== exp_p[k]) $display("FAIL seq6_phase step %0d: got %0d expected %0d", k, phase_m, exp_p[k]); else n_pass++;
        end
        n_checks++; if (polled_cnt - cnt0 !== 6) $display("FAIL polled_count: got %0d expected 6", polled_cnt - cnt0); else n_pass++;
        btn_up = 1'b1;
        tick(1);
        n_checks++; if (lines_m !== 6'b011111) $display("FAIL button_change: got %b expected %b", lines_m, 6'b011111); else n_pass++;
        btn_up = 1'b0;
        tick(1);
        n_checks++; if (lines_m !== 6'b111111) $display("FAIL button_release: got %b expected %b", lines_m, 6'b111111); else n_pass++;
    endtask

    task automatic test_three_button();
        logic [5:0] exp_l [8];
        set_buttons(1'b1, 1'b1, 1'b1);
        exp_l = '{6'b110001, 6'b111111, 6'b110001, 6'b111111,
                  6'b110001, 6'b111111, 6'b110001, 6'b111111};
        sel_m = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            sel_m = (k % 2 == 1);
            tick(126);
            n_checks++; if (lines_b !== exp_l[k]) $display("FAIL seq3_lines step %0d: got %b expected %b", k, lines_b, exp_l[k]); else n_pass++;
            if (k == 5) begin
                n_checks++; if (phase_b !== 3'd3) $display("FAIL seq3_phase: got %0d expected 3", phase_b); else n_pass++;
                n_checks++; if (lines_m !== 6'b110011) $display("FAIL seq6_mode_ext: got %b expected %b", lines_m, 6'b110011); else n_pass++;
            end
        end
    endtask

    task automatic test_timeout_default();
        set_buttons(1'b1, 1'b1, 1'b0);
        sel_m = 1'b0;
        do_reset();
        sel_m = 1'b1; tick(126);
        sel_m = 1'b0; tick(126);
        sel_m = 1'b1; tick(126);
        sel_m = 1'b0; tick(126);
        n_checks++; if (phase_m !== 3'd2) $display("FAIL to_before: got %0d expected 2", phase_m); else n_pass++;
        tick(42000);
        n_checks++; if (phase_m !== 3'd0) $display("FAIL to_expired: got %0d expected 0", phase_m); else n_pass++;
        sel_m = 1'b1; tick(126);
        n_checks++; if (phase_m !== 3'd1) $display("FAIL to_new_pulse: got %0d expected 1", phase_m); else n_pass++;
        n_checks++; if (lines_m !== 6'b111111) $display("FAIL to_new_lines: got %b expected %b", lines_m, 6'b111111); else n_pass++;
        sel_m = 1'b0; tick(126);
        n_checks++; if (lines_m !== 6'b110001) $display("FAIL to_no_premature_detect: got %b expected %b", lines_m, 6'b110001); else n_pass++;
        sel_m = 1'b1; tick(126);
        sel_m = 1'b0; tick(126);
        n_checks++; if (lines_m !== 6'b000001) $display("FAIL to_detect: got %b expected %b", lines_m, 6'b000001); else n_pass++;
    endtask

    task automatic test_timeout_boundary();
        sel_t = 1'b0;
        do_reset();
        sel_t = 1'b1;
        tick(3);
        n_checks++; if (phase_t !== 3'd1) $display("FAIL bnd_first_edge: got %0d expected 1", phase_t); else n_pass++;
        n_checks++; if (polled_t !== 1'b1) $display("FAIL bnd_polled_on: got %b expected 1", polled_t); else n_pass++;
        tick(1);
        n_checks++; if (polled_t !== 1'b0) $display("FAIL bnd_polled_off: got %b expected 0", polled_t); else n_pass++;
        tick(38);
        n_checks++; if (phase_t !== 3'd1) $display("FAIL bnd_timeout_minus1: got %0d expected 1", phase_t); else n_pass++;
        tick(1);
        n_checks++; if (phase_t !== 3'd0) $display("FAIL bnd_timeout_hit: got %0d expected 0", phase_t); else n_pass++;
        sel_t = 1'b0; tick(4);
        sel_t = 1'b1; tick(3);
        sel_t = 1'b0; tick(4);
        sel_t = 1'b1; tick(3);
        n_checks++; if (phase_t !== 3'd2) $display("FAIL bnd_two_edges: got %0d expected 2", phase_t); else n_pass++;
        sel_t = 1'b0; tick(4);
        n_checks++; if (phase_t !== 3'd2) $display("FAIL bnd_fall_no_change: got %0d expected 2", phase_t); else n_pass++;
        tick(33);
        sel_t = 1'b1;
        tick(2);
        n_checks++; if (phase_t !== 3'd2) $display("FAIL bnd_pre_coincide: got %0d expected 2", phase_t); else n_pass++;
        tick(1);
        n_checks++; if (phase_t !== 3'd1) $display("FAIL bnd_edge_wins: got %0d expected 1", phase_t); else n_pass++;
        n_checks++; if (polled_t !== 1'b1) $display("FAIL bnd_edge_polled: got %b expected 1", polled_t); else n_pass++;
        tick(1);
        n_checks++; if (phase_t !== 3'd1) $display("FAIL bnd_idle_cleared: got %0d expected 1", phase_t); else n_pass++;
    endtask

    task automatic test_latency();
        logic [5:0] exp_l [5];
        int d;
        exp_l = '{6'b110001, 6'b111111, 6'b110001, 6'b111111, 6'b000001};
        set_buttons(1'b1, 1'b1, 1'b0);
        sel_m = 1'b0;
        do_reset();
        tick(10);
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(1, 34);
            @(posedge clk28);
            #(d);
            sel_m = ~sel_m;
            tick(1);
            n_checks++; if (lines_m !== exp_l[i]) $display("FAIL lat_edge1 #%0d: got %b expected %b", i, lines_m, exp_l[i]); else n_pass++;
            tick(1);
            n_checks++; if (lines_m !== exp_l[i]) $display("FAIL lat_edge2 #%0d: got %b expected %b", i, lines_m, exp_l[i]); else n_pass++;
            tick(1);
            n_checks++; if (lines_m !== exp_l[i+1]) $display("FAIL lat_edge3 #%0d: got %b expected %b", i, lines_m, exp_l[i+1]); else n_pass++;
            tick(20);
            n_checks++; if (lines_m !== exp_l[i+1]) $display("FAIL lat_stable #%0d: got %b expected %b", i, lines_m, exp_l[i+1]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_sequence();
        set_buttons(1'b1, 1'b1, 1'b0);
        sel_m = 1'b0;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            sel_m = (k % 2 == 1);
            tick(126);
        end
        n_checks++; if (phase_m !== 3'd3) $display("FAIL mid_phase_before: got %0d expected 3", phase_m); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (lines_m !== 6'b111111) $display("FAIL mid_async_lines: got %b expected %b", lines_m, 6'b111111); else n_pass++;
        n_checks++; if (phase_m !== 3'd0) $display("FAIL mid_async_phase: got %0d expected 0", phase_m); else n_pass++;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        n_checks++; if (phase_m !== 3'd0) $display("FAIL mid_after_release: got %0d expected 0", phase_m); else n_pass++;
        sel_m = 1'b1;
        tick(3);
        n_checks++; if (phase_m !== 3'd1) $display("FAIL mid_restart_phase: got %0d expected 1", phase_m); else n_pass++;
        n_checks++; if (polled_m !== 1'b1) $display("FAIL mid_restart_polled: got %b expected 1", polled_m); else n_pass++;
        tick(126);
        n_checks++; if (lines_m !== 6'b111111) $display("FAIL mid_restart_lines: got %b expected %b", lines_m, 6'b111111); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_six_button_sequence();
        test_three_button();
        test_timeout_default();
        test_timeout_boundary();
        test_latency();
        test_reset_mid_sequence();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
